// File: rtl/spi_slave.sv
// SPI responder: oversamples sclk/cs/mosi in the clk domain, supports CPOL/CPHA
// modes 0-3, 1..32-bit MSB-first frames, and a one-cycle rx_valid per frame.
module spi_slave (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpol,
    input  logic        cpha,
    input  logic [5:0]  bit_count,
    input  logic [31:0] tx_data,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    logic        sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic        cs_s1_q, cs_s2_q, cs_h_q;
    logic        mosi_s1_q, mosi_s2_q;

    state_e      state_q, state_d;
    logic        cpol_q, cpol_d;
    logic        cpha_q, cpha_d;
    logic [5:0]  n_q, n_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] tx_q, tx_d;
    logic [31:0] rx_sh_q, rx_sh_d;
    logic [31:0] rx_data_q, rx_data_d;
    logic        miso_q, miso_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;

    logic        sclk_rise_s, sclk_fall_s, lead_s, trail_s;
    logic        sample_edge_s, shift_edge_s;
    logic        cs_fall_s, cs_rise_s, done_now_s;
    logic [5:0]  eff_n_s;
    logic [4:0]  entry_idx_s, tx_idx_s;

    // Edge detection on the synchronised pins and next-state/output logic.
    always_comb begin
        sclk_rise_s   = sclk_s2_q & ~sclk_h_q;
        sclk_fall_s   = ~sclk_s2_q & sclk_h_q;
        lead_s        = cpol_q ? sclk_fall_s : sclk_rise_s;
        trail_s       = cpol_q ? sclk_rise_s : sclk_fall_s;
        sample_edge_s = cpha_q ? trail_s : lead_s;
        shift_edge_s  = cpha_q ? lead_s : trail_s;
        cs_fall_s     = ~cs_s2_q & cs_h_q;
        cs_rise_s     = cs_s2_q & ~cs_h_q;
        eff_n_s       = ((bit_count == 6'd0) || (bit_count > 6'd32)) ? 6'd32 : bit_count;
        // 5-bit wrap makes n = 32 index bit 31.
        entry_idx_s   = eff_n_s[4:0] - 5'd1;
        tx_idx_s      = n_q[4:0] - 5'd1 - cnt_q[4:0];
        done_now_s    = 1'b0;

        state_d     = state_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        tx_d        = tx_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        miso_d      = miso_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_d = ST_ACTIVE;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    n_d     = eff_n_s;
                    tx_d    = tx_data;
                    cnt_d   = 6'd0;
                    rx_sh_d = 32'd0;
                    miso_d  = cpha ? 1'b0 : tx_data[entry_idx_s];
                end else begin
                    miso_d = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (sample_edge_s) begin
                    rx_sh_d = {rx_sh_q[30:0], mosi_s2_q};
                    cnt_d   = cnt_q + 6'd1;
                    if ((cnt_q + 6'd1) == n_q) begin
                        rx_data_d  = {rx_sh_q[30:0], mosi_s2_q};
                        rx_valid_d = 1'b1;
                        state_d    = ST_DONE;
                        miso_d     = 1'b0;
                        done_now_s = 1'b1;
                    end else begin
                        miso_d = miso_q;
                    end
                end else if (shift_edge_s) begin
                    miso_d = tx_q[tx_idx_s];
                end else begin
                    miso_d = miso_q;
                end
                // A completing sample in the same cycle as cs rising wins over the error.
                if (cs_rise_s) begin
                    state_d     = ST_IDLE;
                    miso_d      = 1'b0;
                    frame_err_d = ~done_now_s;
                end else begin
                    frame_err_d = 1'b0;
                end
            end
            ST_DONE: begin
                miso_d = 1'b0;
                if (cs_rise_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    // Pin synchronisers and state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_h_q    <= 1'b0;
            cs_s1_q     <= 1'b0;
            cs_s2_q     <= 1'b0;
            cs_h_q      <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            state_q     <= ST_IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            n_q         <= 6'd32;
            cnt_q       <= 6'd0;
            tx_q        <= 32'd0;
            rx_sh_q     <= 32'd0;
            rx_data_q   <= 32'd0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_s1_q   <= sclk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_h_q    <= sclk_s2_q;
            cs_s1_q     <= cs;
            cs_s2_q     <= cs_s1_q;
            cs_h_q      <= cs_s2_q;
            mosi_s1_q   <= mosi;
            mosi_s2_q   <= mosi_s1_q;
            state_q     <= state_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            miso_q      <= miso_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = (state_q != ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a behavioural SPI master drives frames and
// results are compared with a masking reference model of the exchange.
module tb_spi_slave;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpol = 1'b0, cpha = 1'b0;
    logic [5:0]  bit_count = 6'd8;
    logic [31:0] tx_data = 32'd0;
    logic        sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
    logic        miso, miso_oe, rx_valid, busy, frame_err;
    logic [31:0] rx_data;

    int n_pass = 0;
    int n_total = 0;
    int rv_cnt = 0;
    int fe_cnt = 0;
    logic [31:0] last_rx = 32'd0;

    spi_slave dut (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .bit_count(bit_count),
        .tx_data(tx_data), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    // Reference: an n-bit exchange carries the low n bits of each word; 0 or >32 means 32.
    function automatic logic [31:0] model_mask(input logic [31:0] w, input int n);
        int eff;
        eff = (n == 0 || n > 32) ? 32 : n;
        if (eff == 32) return w;
        return w & ((32'd1 << eff) - 32'd1);
    endfunction

    task automatic master_xfer(input logic p, input logic h, input int nb, input int abort_at,
                               input int extra, input bit perturb, input logic [31:0] mword,
                               output logic [31:0] got, output logic busy_mid, output logic miso_end);
        got = 32'd0;
        busy_mid = 1'b0;
        @(negedge clk);
        sclk = p;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        cs = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (i == abort_at) break;
            if (perturb && i == 2) begin
                tx_data = ~tx_data;
                cpha = ~cpha;
                bit_count = 6'd3;
            end
            if (!h) begin
                mosi = mword[nb-1-i];
                repeat (HALF) @(negedge clk);
                got = {got[30:0], miso};
                sclk = ~p;
                repeat (HALF) @(negedge clk);
                sclk = p;
            end else begin
                repeat (HALF) @(negedge clk);
                sclk = ~p;
                mosi = mword[nb-1-i];
                repeat (HALF) @(negedge clk);
                got = {got[30:0], miso};
                sclk = p;
            end
            if (i == 0) busy_mid = busy;
        end
        for (int e = 0; e < extra; e++) begin
            repeat (HALF) @(negedge clk);
            sclk = ~sclk;
        end
        repeat (HALF) @(negedge clk);
        sclk = p;
        repeat (HALF) @(negedge clk);
        miso_end = miso;
        cs = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({miso, miso_oe, rx_valid, busy, frame_err} !== 5'b0) $display("FAIL reset_ctrl: got %b expected 00000", {miso, miso_oe, rx_valid, busy, frame_err});
        else n_pass++;
        n_total++;
        if (rx_data !== 32'd0) $display("FAIL reset_rx_data: got %h expected 00000000", rx_data);
        else n_pass++;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_mode0_byte;
        logic [31:0] got;
        logic bm, me;
        int rv0, fe0;
        rv0 = rv_cnt; fe0 = fe_cnt;
        cpol = 1'b0; cpha = 1'b0; bit_count = 6'd8; tx_data = 32'h3C;
        master_xfer(1'b0, 1'b0, 8, -1, 0, 1'b0, 32'hA5, got, bm, me);
        repeat (4) @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || miso_oe !== 1'b0) $display("FAIL m0_busy_after: got %b%b expected 00", busy, miso_oe);
        else n_pass++;
        n_total++;
        if (bm !== 1'b1) $display("FAIL m0_busy_mid: got %b expected 1", bm);
        else n_pass++;
        n_total++;
        if (rx_data !== model_mask(32'hA5, 8)) $display("FAIL m0_rx_data: got %h expected %h", rx_data, model_mask(32'hA5, 8));
        else n_pass++;
        n_total++;
        if (got !== model_mask(32'h3C, 8)) $display("FAIL m0_master_rx: got %h expected %h", got, model_mask(32'h3C, 8));
        else n_pass++;
        n_total++;
        if (rv_cnt - rv0 !== 1 || fe_cnt - fe0 !== 0) $display("FAIL m0_pulses: got rv=%0d fe=%0d expected rv=1 fe=0", rv_cnt - rv0, fe_cnt - fe0);
        else n_pass++;
        last_rx = model_mask(32'hA5, 8);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_modes_32;
        logic [31:0] got;
        logic bm, me;
        int rv0;
        for (int m = 1; m < 4; m++) begin
            rv0 = rv_cnt;
            cpol = m[1]; cpha = m[0]; bit_count = 6'd32; tx_data = 32'h12345678;
            master_xfer(m[1], m[0], 32, -1, 0, 1'b0, 32'hDEADBEEF, got, bm, me);
            repeat (8) @(negedge clk);
            n_total++;
            if (rx_data !== 32'hDEADBEEF) $display("FAIL mode%0d_rx_data: got %h expected deadbeef", m, rx_data);
            else n_pass++;
            n_total++;
            if (got !== 32'h12345678) $display("FAIL mode%0d_master_rx: got %h expected 12345678", m, got);
            else n_pass++;
            n_total++;
            if (rv_cnt - rv0 !== 1 || busy !== 1'b0) $display("FAIL mode%0d_done: got rv=%0d busy=%b expected rv=1 busy=0", m, rv_cnt - rv0, busy);
            else n_pass++;
            last_rx = 32'hDEADBEEF;
        end
    endtask

    task automatic test_bit_count_bounds;
        logic [31:0] got;
        logic bm, me;
        logic [5:0] bcs [2];
        bcs[0] = 6'd0; bcs[1] = 6'd40;
        for (int k = 0; k < 2; k++) begin
            cpol = 1'b0; cpha = 1'b1; bit_count = bcs[k]; tx_data = $urandom;
            master_xfer(1'b0, 1'b1, 32, -1, 0, 1'b0, 32'hC0FFEE11 ^ k, got, bm, me);
            repeat (8) @(negedge clk);
            n_total++;
            if (rx_data !== model_mask(32'hC0FFEE11 ^ k, int'(bcs[k]))) $display("FAIL bc%0d_rx_data: got %h expected %h", bcs[k], rx_data, model_mask(32'hC0FFEE11 ^ k, int'(bcs[k])));
            else n_pass++;
            n_total++;
            if (got !== model_mask(tx_data, int'(bcs[k]))) $display("FAIL bc%0d_master_rx: got %h expected %h", bcs[k], got, model_mask(tx_data, int'(bcs[k])));
            else n_pass++;
        end
        cpol = 1'b0; cpha = 1'b0; bit_count = 6'd1; tx_data = 32'hFFFF_FFFE;
        master_xfer(1'b0, 1'b0, 1, -1, 0, 1'b0, 32'h1, got, bm, me);
        repeat (8) @(negedge clk);
        n_total++;
        if (rx_data !== 32'h1) $display("FAIL bc1_rx_data: got %h expected 00000001", rx_data);
        else n_pass++;
        n_total++;
        if (got !== 32'h0) $display("FAIL bc1_master_rx: got %h expected 00000000", got);
        else n_pass++;
        last_rx = 32'h1;
    endtask

    task automatic test_abort;
        logic [31:0] got;
        logic bm, me;
        int rv0, fe0;
        rv0 = rv_cnt; fe0 = fe_cnt;
        cpol = 1'b0; cpha = 1'b0; bit_count = 6'd8; tx_data = 32'h5A;
        master_xfer(1'b0, 1'b0, 8, 5, 0, 1'b0, 32'h96, got, bm, me);
        repeat (8) @(negedge clk);
        n_total++;
        if (fe_cnt - fe0 !== 1 || rv_cnt - rv0 !== 0) $display("FAIL abort_pulses: got fe=%0d rv=%0d expected fe=1 rv=0", fe_cnt - fe0, rv_cnt - rv0);
        else n_pass++;
        n_total++;
        if (rx_data !== last_rx) $display("FAIL abort_rx_hold: got %h expected %h", rx_data, last_rx);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy);
        else n_pass++;
        rv0 = rv_cnt; fe0 = fe_cnt;
        master_xfer(1'b0, 1'b0, 8, -1, 0, 1'b0, 32'h96, got, bm, me);
        repeat (8) @(negedge clk);
        n_total++;
        if (rx_data !== 32'h96 || got !== 32'h5A) $display("FAIL abort_next: got rx=%h mrx=%h expected rx=00000096 mrx=0000005a", rx_data, got);
        else n_pass++;
        n_total++;
        if (rv_cnt - rv0 !== 1 || fe_cnt - fe0 !== 0) $display("FAIL abort_next_pulses: got rv=%0d fe=%0d expected rv=1 fe=0", rv_cnt - rv0, fe_cnt - fe0);
        else n_pass++;
        last_rx = 32'h96;
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] got;
        logic bm, me;
        int rv0;
        cpol = 1'b0; cpha = 1'b0; bit_count = 6'd8; tx_data = 32'hFF;
        @(negedge clk);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({miso, miso_oe, rx_valid, busy, frame_err} !== 5'b0 || rx_data !== 32'd0) $display("FAIL rstmid_outputs: got %b/%h expected 00000/00000000", {miso, miso_oe, rx_valid, busy, frame_err}, rx_data);
        else n_pass++;
        rv0 = rv_cnt;
        for (int e = 0; e < 16; e++) begin
            repeat (HALF) @(negedge clk);
            sclk = ~sclk;
            if (e == 3) begin
                n_total++;
                if (busy !== 1'b0 || miso_oe !== 1'b0) $display("FAIL rstmid_no_start: got %b%b expected 00", busy, miso_oe);
                else n_pass++;
            end
        end
        repeat (HALF) @(negedge clk);
        n_total++;
        if (rv_cnt - rv0 !== 0 || rx_data !== 32'd0) $display("FAIL rstmid_no_frame: got rv=%0d rx=%h expected rv=0 rx=00000000", rv_cnt - rv0, rx_data);
        else n_pass++;
        cs = 1'b1;
        repeat (8) @(negedge clk);
        tx_data = 32'hC3;
        master_xfer(1'b0, 1'b0, 8, -1, 0, 1'b0, 32'h3E, got, bm, me);
        repeat (8) @(negedge clk);
        n_total++;
        if (rx_data !== 32'h3E || got !== 32'hC3) $display("FAIL rstmid_next: got rx=%h mrx=%h expected rx=0000003e mrx=000000c3", rx_data, got);
        else n_pass++;
        last_rx = 32'h3E;
    endtask

    task automatic test_perturb;
        logic [31:0] got, tx0, mw;
        logic bm, me;
        int rv0;
        for (int k = 0; k < 2; k++) begin
            rv0 = rv_cnt;
            tx0 = $urandom;
            mw = $urandom;
            cpol = k[0]; cpha = 1'b0; bit_count = 6'd12; tx_data = tx0;
            master_xfer(k[0], 1'b0, 12, -1, 3, 1'b1, mw, got, bm, me);
            repeat (8) @(negedge clk);
            n_total++;
            if (rx_data !== model_mask(mw, 12) || got !== model_mask(tx0, 12)) $display("FAIL perturb%0d_data: got rx=%h mrx=%h expected rx=%h mrx=%h", k, rx_data, got, model_mask(mw, 12), model_mask(tx0, 12));
            else n_pass++;
            n_total++;
            if (me !== 1'b0) $display("FAIL perturb%0d_miso_end: got %b expected 0", k, me);
            else n_pass++;
            n_total++;
            if (rv_cnt - rv0 !== 1) $display("FAIL perturb%0d_rv_count: got %0d expected 1", k, rv_cnt - rv0);
            else n_pass++;
            last_rx = model_mask(mw, 12);
        end
    endtask

    task automatic test_random;
        logic [31:0] got, mw;
        logic bm, me, p, h;
        int nb, rv0;
        for (int it = 0; it < 10; it++) begin
            p = 1'($urandom_range(0, 1));
            h = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 32);
            mw = $urandom;
            cpol = p; cpha = h; bit_count = 6'(nb); tx_data = $urandom;
            rv0 = rv_cnt;
            master_xfer(p, h, nb, -1, 0, 1'b0, mw, got, bm, me);
            repeat (8) @(negedge clk);
            n_total++;
            if (rx_data !== model_mask(mw, nb) || got !== model_mask(tx_data, nb) || rv_cnt - rv0 !== 1) $display("FAIL rand%0d_mode%0d%0d_n%0d: got rx=%h mrx=%h rv=%0d expected rx=%h mrx=%h rv=1", it, p, h, nb, rx_data, got, rv_cnt - rv0, model_mask(mw, nb), model_mask(tx_data, nb));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_mode0_byte();
        test_modes_32();
        test_bit_count_bounds();
        test_abort();
        test_reset_mid_frame();
        test_perturb();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
